mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of requester ports (range 1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning requester address width.
REQ-003 SHALL have parameter IO_MASK, default 32'h0003_0000, meaning an address is I/O when (addr & IO_MASK) == IO_MASK.
REQ-004 SHALL have port clk, input, 1, meaning system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-006 SHALL have port rdy, input, 1, meaning global enable; when low, all state and outputs hold.
REQ-007 SHALL have port req_valid, input, NUM_PORTS, meaning per-port request pending.
REQ-008 SHALL have port req_wr, input, NUM_PORTS, meaning 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2*NUM_PORTS, meaning 00 = byte, 01 = half, 10/11 = word.
REQ-010 SHALL have port req_addr, input, ADDR_W*NUM_PORTS, meaning byte address.
REQ-011 SHALL have port req_wdata, input, 32*NUM_PORTS, meaning store data, little-endian.
REQ-012 SHALL have port req_flush, input, NUM_PORTS, meaning abort the in-flight load of that port.
REQ-013 SHALL have port resp_done, output, NUM_PORTS, meaning one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata, output, 32, meaning load result, zero-extended; valid while resp_done is high.
REQ-015 SHALL have ports mem_din (input, 8), mem_dout (output, 8), mem_a (output, 32) and mem_wr (output, 1, 1 = write) forming the byte RAM bus; read data appears on mem_din one cycle after mem_a.
REQ-016 SHALL have port io_buffer_full, input, 1, meaning the I/O write sink cannot accept data.

Function
REQ-017 SHALL implement states IDLE and BUSY.
REQ-018 In IDLE, SHALL grant one eligible port per edge, searching round-robin from (last_grant+1) mod NUM_PORTS.
REQ-019 A port SHALL be eligible when req_valid is high, it is not the port pulsing resp_done this cycle, and it is not an I/O store while io_buffer_full is high.
REQ-020 At the grant edge E0, SHALL register mem_a=addr, mem_wr=req_wr, mem_dout=wdata[7:0] (store), cnt=0, last_grant=port, and move to BUSY.
REQ-021 On n = 1/2/4 bytes, byte i SHALL be driven at edge Ei with address addr+i, wrapping modulo 2^32.
REQ-022 For a load, at edge Ei (i=1..n) SHALL capture mem_din into rdata byte i-1; unused upper bytes SHALL be zero.
REQ-023 For a store, mem_dout at edge Ei SHALL be wdata byte i; mem_wr SHALL be driven low at edge En.
REQ-024 At edge En, SHALL set resp_done[port] high for exactly one cycle and return to IDLE; latency grant-to-done = n cycles.
REQ-025 A requester SHALL hold all req_* stable from assertion until it samples resp_done; the arbiter SHALL NOT re-grant that port in the done cycle.
REQ-026 A flush of the granted port during a BUSY load SHALL return the block to IDLE at the next edge with no resp_done pulse and mem_a unchanged.
REQ-027 A flush during a store SHALL be ignored; the store SHALL complete.
REQ-028 A flush of a non-granted port SHALL have no effect.
REQ-029 rdy low SHALL freeze cnt, state, outputs and rdata; a resp_done pulse SHALL extend for as long as rdy stays low.

Reset
REQ-030 rst SHALL set state=IDLE, cnt=0, last_grant=NUM_PORTS-1, resp_done=0, resp_rdata=0, mem_a=0, mem_dout=0 and mem_wr=0.
REQ-031 rst asserted mid-transfer SHALL abandon the transfer with no resp_done pulse, and mem_wr SHALL be low from the next cycle.

Structure
REQ-032 Size encodings, state encodings and the IO_MASK default SHALL reside in the shared package mem_pkg.
REQ-033 Round-robin selection SHALL be one sub-module, rr_arbiter #(NUM_PORTS), that is purely combinational (request and eligibility vectors plus pointer in, one-hot grant out).

Verification
REQ-034 Port0 load word at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; resp_done[0] 4 cycles after grant; rdata=0x44332211.
REQ-035 Port1 store half 0xBEEF at 0x200 -> writes EF@0x200 then BE@0x201 with mem_wr=1; mem_wr=0 and resp_done[1] 2 cycles after grant.
REQ-036 Ports 0 and 1 both held valid with byte loads -> grants alternate 0,1,0,1; no port is granted twice in a row.
REQ-037 Port0 word load with req_flush[0] asserted after byte 1 -> IDLE next cycle; no resp_done; pending port1 is granted next.
REQ-038 Port1 store byte to 0x30000 with io_buffer_full=1 for 5 cycles -> no grant and mem_wr=0 throughout; grant on the first cycle after io_buffer_full drops.
REQ-039 rdy low for 3 cycles mid word load, and separately rst mid word store -> outputs frozen then rdata still correct; after rst, mem_wr=0 and no resp_done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory port arbiter: transfer size
// encodings, controller state encodings, default I/O address mask and small
// helper functions used by the arbiter and its round-robin selector.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [31:0] IO_MASK_DEFAULT = 32'h0003_0000;

    // Number of bytes moved for a request size code (both 10 and 11 mean word).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        if (size == SZ_BYTE)
            n = 3'd1;
        else if (size == SZ_HALF)
            n = 3'd2;
        else
            n = 3'd4;
        return n;
    endfunction

    // Width of a port index; a single-port build still gets a one-bit index.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Purely combinational round-robin selector. The search starts at the port
// after ptr (the last granted port) and wraps; the first port that is both
// requesting and eligible receives a one-hot grant.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 2
)(
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        elig,
    input  logic [ptr_w(NUM_PORTS)-1:0] ptr,
    output logic [NUM_PORTS-1:0]        grant
);

    localparam int PTR_W = ptr_w(NUM_PORTS);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the ports in rotated order and keep only the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
            if (!found && req[idx] && elig[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-port arbiter in front of a byte-wide RAM bus. One request at a time
// is granted round-robin and then moved one byte per cycle (1, 2 or 4 bytes,
// little-endian). Loads assemble a zero-extended result; stores stream the
// data bytes. A one-cycle resp_done pulse marks completion, loads can be
// aborted by the owning port's flush, and rdy low freezes everything.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int          NUM_PORTS = 2,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] IO_MASK   = IO_MASK_DEFAULT
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [2*NUM_PORTS-1:0]      req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]        req_flush,
    output logic [NUM_PORTS-1:0]        resp_done,
    output logic [31:0]                 resp_rdata,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [31:0]                 mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full
);

    localparam int PTR_W = ptr_w(NUM_PORTS);

    // Per-port views of the flattened request buses
    logic [31:0]          port_addr  [NUM_PORTS];
    logic [31:0]          port_wdata [NUM_PORTS];
    logic [1:0]           port_size  [NUM_PORTS];
    logic [NUM_PORTS-1:0] elig;

    // Arbitration results
    logic [NUM_PORTS-1:0] grant_vec;
    logic [PTR_W-1:0]     grant_idx;

    // Controller state and the latched copy of the granted request
    state_e           state;
    state_e           state_next;
    logic [2:0]       cnt;
    logic [2:0]       cnt_inc;
    logic [PTR_W-1:0] last_grant;
    logic [PTR_W-1:0] gport;
    logic             g_wr;
    logic [2:0]       g_n;
    logic [31:0]      g_addr;
    logic [31:0]      g_wdata;

    // Per-edge actions decided by the output logic
    logic do_grant;
    logic do_step;
    logic do_finish;
    logic do_abort;

    assign cnt_inc = cnt + 3'd1;

    // Split the flat buses per port and work out which ports may be granted.
    always_comb begin
        port_addr  = '{default: '0};
        port_wdata = '{default: '0};
        port_size  = '{default: '0};
        elig       = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_addr[p]  = 32'(req_addr[p*ADDR_W +: ADDR_W]);
            port_wdata[p] = req_wdata[p*32 +: 32];
            port_size[p]  = req_size[p*2 +: 2];
            // A port whose completion is being signalled must not be re-granted
            // in the same cycle; I/O stores wait while the sink is full.
            elig[p] = !resp_done[p] &&
                      !(req_wr[p] && io_buffer_full &&
                        ((port_addr[p] & IO_MASK) == IO_MASK));
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req   (req_valid),
        .elig  (elig),
        .ptr   (last_grant),
        .grant (grant_vec)
    );

    // Convert the one-hot grant into a port index.
    always_comb begin
        grant_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_vec[p])
                grant_idx = PTR_W'(p);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; the action flags already include rdy.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (do_grant)              state_next = ST_BUSY;
            ST_BUSY: if (do_finish || do_abort) state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // Output logic: choose this edge's action. A flush only aborts a load.
    always_comb begin
        do_grant  = 1'b0;
        do_step   = 1'b0;
        do_finish = 1'b0;
        do_abort  = 1'b0;
        if (rdy) begin
            case (state)
                ST_IDLE: do_grant = |grant_vec;
                ST_BUSY: begin
                    if (!g_wr && req_flush[gport])
                        do_abort = 1'b1;
                    else if (cnt_inc == g_n)
                        do_finish = 1'b1;
                    else
                        do_step = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus, counter and result registers; nothing moves while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 3'd0;
            last_grant <= PTR_W'(NUM_PORTS - 1);
            gport      <= '0;
            g_wr       <= 1'b0;
            g_n        <= 3'd1;
            resp_done  <= '0;
            resp_rdata <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else if (rdy) begin
            resp_done <= '0;
            if (do_grant) begin
                mem_a      <= port_addr[grant_idx];
                mem_wr     <= req_wr[grant_idx];
                mem_dout   <= port_wdata[grant_idx][7:0];
                cnt        <= 3'd0;
                last_grant <= grant_idx;
                gport      <= grant_idx;
                g_wr       <= req_wr[grant_idx];
                g_n        <= size_bytes(port_size[grant_idx]);
                g_addr     <= port_addr[grant_idx];
                g_wdata    <= port_wdata[grant_idx];
                resp_rdata <= '0;
            end
            // mem_din now holds the byte addressed during the previous cycle.
            if (do_step) begin
                cnt      <= cnt_inc;
                mem_a    <= g_addr + 32'(cnt_inc);
                mem_dout <= g_wdata[{cnt_inc[1:0], 3'b000} +: 8];
                if (!g_wr)
                    resp_rdata[{cnt[1:0], 3'b000} +: 8] <= mem_din;
            end
            if (do_finish) begin
                cnt              <= 3'd0;
                mem_wr           <= 1'b0;
                resp_done[gport] <= 1'b1;
                if (!g_wr)
                    resp_rdata[{cnt[1:0], 3'b000} +: 8] <= mem_din;
            end
            if (do_abort)
                cnt <= 3'd0;
        end
    end

endmodule
